ac_bank: RTL and testbench

//  Parametrised accumulator bank for the CPU datapath: NUM_ACC N-bit accumulators plus the R register.

---
 rtl/ac_bank.sv | 118 +++++++++++
 tb/tb_ac_bank.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ac_bank.sv
// Accumulator bank: NUM_ACC N-bit accumulators plus the R register, with bus/ALU
// loads, inc/dec/clr and a one-bit-per-cycle shift engine driven by a small FSM.
module ac_bank #(
    parameter int N          = 16,
    parameter int NUM_ACC    = 4,
    parameter int SEL_W      = 4,
    parameter int AC_RD_CODE = 5,
    parameter int R_RD_CODE  = 13,
    localparam int ASW       = $clog2(NUM_ACC),
    localparam int ASH       = $clog2(N) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ASW-1:0]   acc_sel,
    input  logic             write_en,
    input  logic [SEL_W-1:0] read_en,
    input  logic [N-1:0]     datain,
    input  logic [N-1:0]     alu_out,
    input  logic             alu_to_ac,
    input  logic             inc_en,
    input  logic             dec_en,
    input  logic             clr_en,
    input  logic             shift_start,
    input  logic             shift_dir,
    input  logic [ASH-1:0]   shift_amt,
    output logic [N-1:0]     dataout,
    output logic [N-1:0]     r_out,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [SEL_W-1:0] AC_CODE = SEL_W'(AC_RD_CODE);
    localparam logic [SEL_W-1:0] R_CODE  = SEL_W'(R_RD_CODE);
    localparam logic [ASH-1:0]   CNT_ONE = ASH'(1);

    logic [N-1:0]   acc [NUM_ACC];
    logic [1:0]     state;
    logic [ASH-1:0] cnt;
    logic [ASW-1:0] sh_sel;
    logic           sh_dir;
    logic           carry;
    logic           bus_load;

    assign bus_load   = write_en | (read_en == AC_CODE);
    assign dataout    = acc[acc_sel];
    assign zero_flag  = (dataout == '0);
    assign carry_flag = carry;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            sh_sel <= '0;
            sh_dir <= 1'b0;
            carry  <= 1'b0;
            for (int unsigned i = 0; i < NUM_ACC; i++) begin
                acc[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    // A shift request pre-empts any accumulator op in the same cycle.
                    if (shift_start) begin
                        sh_sel <= acc_sel;
                        sh_dir <= shift_dir;
                        cnt    <= shift_amt;
                        state  <= (shift_amt == '0) ? ST_DONE : ST_SHIFT;
                    end else if (alu_to_ac) begin
                        acc[acc_sel] <= alu_out;
                    end else if (bus_load) begin
                        acc[acc_sel] <= datain;
                    end else if (clr_en) begin
                        acc[acc_sel] <= '0;
                        carry        <= 1'b0;
                    end else if (inc_en && !dec_en) begin
                        acc[acc_sel] <= acc[acc_sel] + 1'b1;
                        carry        <= (acc[acc_sel] == '1);
                    end else if (dec_en && !inc_en) begin
                        acc[acc_sel] <= acc[acc_sel] - 1'b1;
                        carry        <= (acc[acc_sel] == '0);
                    end
                end
                ST_SHIFT: begin
                    if (sh_dir) begin
                        acc[sh_sel] <= acc[sh_sel] >> 1;
                        carry       <= acc[sh_sel][0];
                    end else begin
                        acc[sh_sel] <= acc[sh_sel] << 1;
                        carry       <= acc[sh_sel][N-1];
                    end
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else if (read_en == R_CODE) begin
            r_out <= datain;
        end
    end

endmodule

// File: tb/tb_ac_bank.sv
// Directed self-checking bench for ac_bank (N=16, NUM_ACC=4): loads, inc/dec,
// priority, shifts and reset behaviour, each scenario checked inline.
module tb_ac_bank;

    logic        clk;
    logic        rst;
    logic [1:0]  acc_sel;
    logic        write_en;
    logic [3:0]  read_en;
    logic [15:0] datain;
    logic [15:0] alu_out;
    logic        alu_to_ac;
    logic        inc_en;
    logic        dec_en;
    logic        clr_en;
    logic        shift_start;
    logic        shift_dir;
    logic [4:0]  shift_amt;
    logic [15:0] dataout;
    logic [15:0] r_out;
    logic        zero_flag;
    logic        carry_flag;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fail;

    ac_bank #(
        .N(16), .NUM_ACC(4), .SEL_W(4), .AC_RD_CODE(5), .R_RD_CODE(13)
    ) dut (
        .clk(clk), .rst(rst), .acc_sel(acc_sel), .write_en(write_en),
        .read_en(read_en), .datain(datain), .alu_out(alu_out),
        .alu_to_ac(alu_to_ac), .inc_en(inc_en), .dec_en(dec_en),
        .clr_en(clr_en), .shift_start(shift_start), .shift_dir(shift_dir),
        .shift_amt(shift_amt), .dataout(dataout), .r_out(r_out),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        write_en = 0; read_en = 0; datain = '0; alu_out = '0; alu_to_ac = 0;
        inc_en = 0; dec_en = 0; clr_en = 0; shift_start = 0; shift_dir = 0;
        shift_amt = '0;
    endtask

    task automatic load(input logic [1:0] sel, input logic [15:0] val);
        acc_sel = sel; write_en = 1; datain = val;
        step();
        write_en = 0;
    endtask

    task automatic test_reset();
        load(2'd0, 16'h1111); load(2'd1, 16'h2222);
        load(2'd2, 16'h3333); load(2'd3, 16'h0000);
        dec_en = 1; step(); dec_en = 0;            // acc3 wraps, carry = 1
        read_en = 4'd13; datain = 16'hBEEF; step(); read_en = 0;
        rst = 1; step(); rst = 0;
        n_checks++; if (r_out !== 16'h0) begin n_fail++; $display("FAIL reset_r_out got %h exp 0000", r_out); end
        n_checks++; if (carry_flag !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b exp 0", carry_flag); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got %b%b exp 00", busy, done); end
        for (int s = 0; s < 4; s++) begin
            acc_sel = 2'(s); #1;
            n_checks++; if (dataout !== 16'h0 || zero_flag !== 1'b1) begin
                n_fail++; $display("FAIL reset_acc%0d got %h z=%b exp 0000 z=1", s, dataout, zero_flag);
            end
        end
    endtask

    task automatic test_inc_dec();
        load(2'd2, 16'hFFFF);
        inc_en = 1; step(); inc_en = 0;
        n_checks++; if (dataout !== 16'h0 || carry_flag !== 1'b1 || zero_flag !== 1'b1) begin
            n_fail++; $display("FAIL inc_wrap got %h c=%b z=%b exp 0000 c=1 z=1", dataout, carry_flag, zero_flag);
        end
        inc_en = 1; dec_en = 1; step(); inc_en = 0; dec_en = 0;
        n_checks++; if (dataout !== 16'h0 || carry_flag !== 1'b1) begin
            n_fail++; $display("FAIL inc_dec_both got %h c=%b exp 0000 c=1", dataout, carry_flag);
        end
        dec_en = 1; step(); dec_en = 0;
        n_checks++; if (dataout !== 16'hFFFF || carry_flag !== 1'b1 || zero_flag !== 1'b0) begin
            n_fail++; $display("FAIL dec_wrap got %h c=%b exp ffff c=1", dataout, carry_flag);
        end
        dec_en = 1; step(); dec_en = 0;
        n_checks++; if (dataout !== 16'hFFFE || carry_flag !== 1'b0) begin
            n_fail++; $display("FAIL dec_plain got %h c=%b exp fffe c=0", dataout, carry_flag);
        end
    endtask

    task automatic test_priority();
        load(2'd3, 16'h0000);
        dec_en = 1; step(); dec_en = 0;            // carry = 1 before the loads
        alu_to_ac = 1; alu_out = 16'h1234; write_en = 1; clr_en = 1; inc_en = 1;
        read_en = 4'd13; datain = 16'hAAAA;
        step(); idle_inputs();
        n_checks++; if (dataout !== 16'h1234 || carry_flag !== 1'b1) begin
            n_fail++; $display("FAIL prio_alu got %h c=%b exp 1234 c=1", dataout, carry_flag);
        end
        n_checks++; if (r_out !== 16'hAAAA) begin n_fail++; $display("FAIL r_load got %h exp aaaa", r_out); end
        write_en = 1; datain = 16'h5678; clr_en = 1; inc_en = 1; step(); idle_inputs();
        n_checks++; if (dataout !== 16'h5678 || carry_flag !== 1'b1) begin
            n_fail++; $display("FAIL prio_bus got %h c=%b exp 5678 c=1", dataout, carry_flag);
        end
        read_en = 4'd5; datain = 16'h4321; clr_en = 1; step(); idle_inputs();
        n_checks++; if (dataout !== 16'h4321 || r_out !== 16'hAAAA) begin
            n_fail++; $display("FAIL rd_code_acc got %h r=%h exp 4321 r=aaaa", dataout, r_out);
        end
        clr_en = 1; inc_en = 1; step(); idle_inputs();
        n_checks++; if (dataout !== 16'h0 || carry_flag !== 1'b0 || zero_flag !== 1'b1) begin
            n_fail++; $display("FAIL prio_clr got %h c=%b z=%b exp 0000 c=0 z=1", dataout, carry_flag, zero_flag);
        end
    endtask

    task automatic test_shift_left();
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0; done_cnt = 0;
        load(2'd0, 16'h00AA);
        load(2'd1, 16'h8001);
        acc_sel = 2'd1; shift_start = 1; shift_dir = 0; shift_amt = 5'd3; inc_en = 1;
        step();
        for (int c = 0; c < 10; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                n_checks++; if (dataout !== 16'h0008 || carry_flag !== 1'b0) begin
                    n_fail++; $display("FAIL shl_result got %h c=%b exp 0008 c=0", dataout, carry_flag);
                end
                idle_inputs();
            end
            if (busy) acc_sel = 2'd1;
            step();
        end
        idle_inputs();
        n_checks++; if (busy_cnt !== 4) begin n_fail++; $display("FAIL shl_busy_cycles got %0d exp 4", busy_cnt); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL shl_done_pulses got %0d exp 1", done_cnt); end
        n_checks++; if (dataout !== 16'h0008) begin n_fail++; $display("FAIL shl_after got %h exp 0008", dataout); end
        acc_sel = 2'd0; #1;
        n_checks++; if (dataout !== 16'h00AA) begin n_fail++; $display("FAIL shl_other_acc got %h exp 00aa", dataout); end
    endtask

    task automatic test_shift_right();
        int done_cnt;
        int busy_cnt;
        load(2'd0, 16'h0003);
        shift_start = 1; shift_dir = 1; shift_amt = 5'd1; step(); idle_inputs();
        done_cnt = 0;
        for (int c = 0; c < 10 && done_cnt == 0; c++) begin
            if (done) done_cnt++; else step();
        end
        n_checks++; if (done_cnt !== 1 || dataout !== 16'h0001 || carry_flag !== 1'b1) begin
            n_fail++; $display("FAIL shr_one got %h c=%b done=%0d exp 0001 c=1 done=1", dataout, carry_flag, done_cnt);
        end
        step();
        shift_start = 1; shift_dir = 0; shift_amt = 5'd0; step(); idle_inputs();
        n_checks++; if (done !== 1'b1 || busy !== 1'b1 || dataout !== 16'h0001 || carry_flag !== 1'b1) begin
            n_fail++; $display("FAIL shift_zero got done=%b busy=%b %h c=%b exp 1 1 0001 c=1", done, busy, dataout, carry_flag);
        end
        step();
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL shift_zero_end got done=%b busy=%b exp 0 0", done, busy);
        end
        load(2'd0, 16'hFFFF);
        shift_start = 1; shift_dir = 1; shift_amt = 5'd20; step(); idle_inputs();
        busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 40 && done_cnt == 0; c++) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++; else step();
        end
        n_checks++; if (done_cnt !== 1 || busy_cnt !== 21 || dataout !== 16'h0 || carry_flag !== 1'b0) begin
            n_fail++; $display("FAIL shr_over got %h c=%b busy=%0d done=%0d exp 0000 c=0 busy=21 done=1",
                               dataout, carry_flag, busy_cnt, done_cnt);
        end
        step();
    endtask

    task automatic test_reset_mid_shift();
        int done_cnt;
        load(2'd2, 16'h00FF);
        read_en = 4'd13; datain = 16'h5555; step(); read_en = 0;
        shift_start = 1; shift_dir = 0; shift_amt = 5'd8; step(); idle_inputs();
        step(); step();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b exp 1", busy); end
        rst = 1; step(); rst = 0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || r_out !== 16'h0 || carry_flag !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst got busy=%b done=%b r=%h c=%b exp 0 0 0000 0", busy, done, r_out, carry_flag);
        end
        for (int s = 0; s < 4; s++) begin
            acc_sel = 2'(s); #1;
            n_checks++; if (dataout !== 16'h0) begin n_fail++; $display("FAIL mid_rst_acc%0d got %h exp 0000", s, dataout); end
        end
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (done || busy) done_cnt++;
            step();
        end
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL mid_rst_no_done got %0d exp 0", done_cnt); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1; acc_sel = '0; idle_inputs();
        step(); step();
        rst = 0;
        test_reset();
        test_inc_dec();
        test_priority();
        test_shift_left();
        test_shift_right();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
